// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one sequential 8x8 multiplier among N_REQ requesters.
// One request is in flight at a time; a stalled multiplier is aborted after TIMEOUT wait cycles.
module mul_arbiter #(
    parameter int  N_REQ   = 4,
    parameter int  TIMEOUT = 16,
    localparam int IDW     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [8*N_REQ-1:0] req_a_i,
    input  logic [8*N_REQ-1:0] req_b_i,
    output logic [N_REQ-1:0]   req_ack_o,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [IDW-1:0]     rsp_id_o,
    output logic [15:0]        rsp_m_o,
    output logic               rsp_err_o,
    output logic               mul_start_o,
    output logic [7:0]         mul_a_o,
    output logic [7:0]         mul_b_o,
    input  logic               mul_ready_i,
    input  logic [15:0]        mul_m_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e           state_q;
    logic [N_REQ-1:0] req_ack_q;
    logic             rsp_valid_q;
    logic [IDW-1:0]   rsp_id_q;
    logic [15:0]      rsp_m_q;
    logic             rsp_err_q;
    logic             mul_start_q;
    logic [7:0]       mul_a_q;
    logic [7:0]       mul_b_q;
    logic [4:0]       cnt_q;
    logic [IDW-1:0]   last_grant_q;

    logic [IDW-1:0]   scan_idx_s;
    logic [IDW-1:0]   grant_idx_s;
    logic             grant_found_s;
    logic [N_REQ-1:0] grant_onehot_s;
    logic [7:0]       grant_a_s;
    logic [7:0]       grant_b_s;

    // Round-robin search starting one past the previous winner.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        scan_idx_s    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            scan_idx_s = IDW'((int'(last_grant_q) + k) % N_REQ);
            if (!grant_found_s && req_valid_i[scan_idx_s]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = scan_idx_s;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Operand select and one-hot acknowledge for the chosen requester.
    always_comb begin
        grant_a_s      = 8'd0;
        grant_b_s      = 8'd0;
        grant_onehot_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx_s == IDW'(i)) begin
                grant_a_s         = req_a_i[8*i +: 8];
                grant_b_s         = req_b_i[8*i +: 8];
                grant_onehot_s[i] = 1'b1;
            end else begin
                grant_onehot_s[i] = 1'b0;
            end
        end
    end

    // Control FSM; every output is a register so nothing glitches with req_* inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            req_ack_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_m_q      <= 16'd0;
            rsp_err_q    <= 1'b0;
            mul_start_q  <= 1'b0;
            mul_a_q      <= 8'd0;
            mul_b_q      <= 8'd0;
            cnt_q        <= 5'd0;
            last_grant_q <= IDW'(N_REQ - 1);
        end else begin
            req_ack_q   <= '0;
            mul_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_found_s) begin
                        req_ack_q    <= grant_onehot_s;
                        last_grant_q <= grant_idx_s;
                        rsp_id_q     <= grant_idx_s;
                        mul_a_q      <= grant_a_s;
                        mul_b_q      <= grant_b_s;
                        state_q      <= START;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                START: begin
                    mul_start_q <= 1'b1;
                    cnt_q       <= 5'd0;
                    state_q     <= WAIT;
                end
                WAIT: begin
                    // A result arriving on the final wait cycle takes priority over the timeout.
                    if (mul_ready_i) begin
                        rsp_m_q     <= mul_m_i;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (cnt_q == 5'(TIMEOUT - 1)) begin
                        rsp_m_q     <= 16'd0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        state_q <= RESP;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign req_ack_o   = req_ack_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_m_o     = rsp_m_q;
    assign rsp_err_o   = rsp_err_q;
    assign mul_start_o = mul_start_q;
    assign mul_a_o     = mul_a_q;
    assign mul_b_o     = mul_b_q;

endmodule
